// File: rtl/db15_serial_poller.sv
// Serial poller for the SNAC DB15 adapter: loads, shifts in 24 active-low bits per frame,
// and publishes two 2-frame-debounced active-high joystick words.
module db15_serial_poller #(
  parameter int unsigned CLK_DIV   = 20,
  parameter int unsigned GAP_TICKS = 1000,
  parameter int unsigned NBITS     = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int unsigned BitW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StShiftLo = 3'd2;
  localparam logic [2:0] StShiftHi = 3'd3;
  localparam logic [2:0] StCommit  = 3'd4;
  localparam logic [2:0] StGap     = 3'd5;

  logic             sync_meta_q, sync_q;
  logic [DivW-1:0]  div_q, div_d;
  logic [2:0]       state_q, state_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [NBITS-1:0] raw_q, raw_d;
  logic [NBITS-1:0] prev_q, prev_d;
  logic [11:0]      joy1_q, joy1_d;
  logic [11:0]      joy2_q, joy2_d;
  logic             strobe_q, strobe_d;
  logic             clk_q, clk_d;
  logic             load_q, load_d;
  logic             tick;

  always_comb begin
    tick = (div_q == DivW'(CLK_DIV - 1));
    // COMMIT is an extra cycle inserted between ticks, so the prescaler holds during it.
    if (state_q == StCommit) begin
      div_d = div_q;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    strobe_d = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      bit_d   = '0;
      gap_d   = '0;
      raw_d   = '0;
      prev_d  = '0;
      joy1_d  = '0;
      joy2_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick) state_d = StLoad;
        end
        StLoad: begin
          if (tick) begin
            state_d = StShiftLo;
            bit_d   = '0;
          end
        end
        StShiftLo: begin
          if (tick) begin
            raw_d[bit_q] = ~sync_q;
            state_d      = StShiftHi;
          end
        end
        StShiftHi: begin
          if (tick) begin
            if (bit_q == BitW'(NBITS - 1)) begin
              state_d = StCommit;
            end else begin
              bit_d   = bit_q + 1'b1;
              state_d = StShiftLo;
            end
          end
        end
        StCommit: begin
          if (raw_q == prev_q) begin
            joy1_d   = raw_q[11:0];
            joy2_d   = raw_q[23:12];
            strobe_d = 1'b1;
          end
          prev_d  = raw_q;
          gap_d   = '0;
          state_d = StGap;
        end
        StGap: begin
          if (tick) begin
            if (gap_q == GapW'(GAP_TICKS - 1)) begin
              gap_d   = '0;
              state_d = StLoad;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Lines are registered from the next state so they align exactly with state_q.
    clk_d  = (state_d != StShiftLo);
    load_d = (state_d != StLoad);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b1;
      sync_q      <= 1'b1;
      div_q       <= '0;
      state_q     <= StIdle;
      bit_q       <= '0;
      gap_q       <= '0;
      raw_q       <= '0;
      prev_q      <= '0;
      joy1_q      <= '0;
      joy2_q      <= '0;
      strobe_q    <= 1'b0;
      clk_q       <= 1'b1;
      load_q      <= 1'b1;
    end else begin
      sync_meta_q <= JOY_DATA;
      sync_q      <= sync_meta_q;
      div_q       <= div_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      joy1_q      <= joy1_d;
      joy2_q      <= joy2_d;
      strobe_q    <= strobe_d;
      clk_q       <= clk_d;
      load_q      <= load_d;
    end
  end

  assign JOY_CLK      = clk_q;
  assign JOY_LOAD     = load_q;
  assign joystick1    = {4'b0000, joy1_q};
  assign joystick2    = {4'b0000, joy2_q};
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_db15_serial_poller.sv
// Directed bench for db15_serial_poller with a behavioural DB15 adapter shift-register model.
module tb_db15_serial_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_strobe;

  int checks = 0;
  int errors = 0;

  // Adapter model: pattern is active-high in raw layout {p2, p1}; wire is active-low, bit 0 first.
  logic [23:0] pattern = '0;
  logic [23:0] sh = '1;
  bit          absent = 1'b0;

  assign joy_data = absent ? 1'b1 : sh[0];

  always @(negedge joy_load) sh = ~pattern;
  always @(posedge joy_clk) sh = {1'b1, sh[23:1]};

  always #5 clk = ~clk;

  db15_serial_poller #(
    .CLK_DIV  (4),
    .GAP_TICKS(8),
    .NBITS    (24)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .enable      (enable),
    .JOY_DATA    (joy_data),
    .JOY_CLK     (joy_clk),
    .JOY_LOAD    (joy_load),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .frame_strobe(frame_strobe)
  );

  task automatic wait_strobe(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (frame_strobe) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int lines_bad, strobes, outs_bad;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (joy_clk !== 1'b1) begin errors++; $display("FAIL reset_joy_clk: got %b want 1", joy_clk); end
    checks++;
    if (joy_load !== 1'b1) begin errors++; $display("FAIL reset_joy_load: got %b want 1", joy_load); end
    checks++;
    if (joystick1 !== 16'h0 || joystick2 !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h want 0000/0000", joystick1, joystick2);
    end
    checks++;
    if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", frame_strobe); end
    reset = 1'b0;
    lines_bad = 0; strobes = 0; outs_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (joy_clk !== 1'b1 || joy_load !== 1'b1) lines_bad++;
      if (frame_strobe !== 1'b0) strobes++;
      if (joystick1 !== 16'h0 || joystick2 !== 16'h0) outs_bad++;
    end
    checks++;
    if (lines_bad != 0) begin errors++; $display("FAIL idle_lines: got %0d active cycles want 0", lines_bad); end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL idle_strobe: got %0d strobes want 0", strobes); end
    checks++;
    if (outs_bad != 0) begin errors++; $display("FAIL idle_outputs: got %0d nonzero cycles want 0", outs_bad); end
  endtask

  task automatic test_frame_timing;
    int n, w, pulses, bad_w, lo, p;
    absent = 1'b1;
    enable = 1'b1;
    n = 0;
    while (joy_load && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (joy_load !== 1'b0) begin errors++; $display("FAIL load_start: got no LOAD in %0d cycles want LOAD", n); end
    w = 0;
    while (!joy_load && w < 20) begin w++; @(negedge clk); end
    checks++;
    if (w != 4) begin errors++; $display("FAIL load_width: got %0d want 4", w); end
    pulses = 0; bad_w = 0; lo = 0; n = 0;
    while (!frame_strobe && n < 400) begin
      if (!joy_clk) lo++;
      else if (lo != 0) begin
        pulses++;
        if (lo != 4) bad_w++;
        lo = 0;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_strobe !== 1'b1) begin errors++; $display("FAIL frame_strobe_seen: got 0 want 1"); end
    checks++;
    if (pulses != 24) begin errors++; $display("FAIL clk_pulses: got %0d want 24", pulses); end
    checks++;
    if (bad_w != 0) begin errors++; $display("FAIL clk_low_width: got %0d bad pulses want 0", bad_w); end
    checks++;
    if (joystick1 !== 16'h0 || joystick2 !== 16'h0) begin
      errors++; $display("FAIL absent_outputs: got %h/%h want 0000/0000", joystick1, joystick2);
    end
    @(negedge clk);
    checks++;
    if (frame_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b want 0", frame_strobe); end
    p = 1;
    while (!frame_strobe && p < 400) begin @(negedge clk); p++; end
    checks++;
    if (p != 229) begin errors++; $display("FAIL frame_period: got %0d want 229", p); end
  endtask

  task automatic test_decode;
    int cyc;
    bit ok;
    absent = 1'b0;
    pattern = {12'hA00, 12'h005};
    wait_strobe(600, cyc, ok);
    checks++;
    if (!ok || cyc != 458) begin errors++; $display("FAIL decode_latency: got %0d (seen %0d) want 458", cyc, ok); end
    checks++;
    if (joystick1 !== 16'h0005) begin errors++; $display("FAIL decode_joy1: got %h want 0005", joystick1); end
    checks++;
    if (joystick2 !== 16'h0A00) begin errors++; $display("FAIL decode_joy2: got %h want 0a00", joystick2); end
    @(negedge clk);
    checks++;
    if (frame_strobe !== 1'b0) begin errors++; $display("FAIL decode_strobe_width: got %b want 0", frame_strobe); end
  endtask

  task automatic test_debounce;
    int n, cyc;
    bit ok;
    pattern = {12'hA00, 12'h00D};
    n = 0;
    while (joy_load && n < 300) begin @(negedge clk); n++; end
    pattern = {12'hA00, 12'h005};
    wait_strobe(900, cyc, ok);
    checks++;
    if (!ok || cyc != 655) begin errors++; $display("FAIL glitch_strobe_time: got %0d want 655", cyc); end
    checks++;
    if (joystick1 !== 16'h0005) begin errors++; $display("FAIL glitch_filtered: got %h want 0005", joystick1); end
    pattern = {12'hA00, 12'h00D};
    wait_strobe(900, cyc, ok);
    checks++;
    if (!ok || cyc != 458) begin errors++; $display("FAIL hold_strobe_time: got %0d want 458", cyc); end
    checks++;
    if (joystick1 !== 16'h000D || joystick2 !== 16'h0A00) begin
      errors++; $display("FAIL hold_update: got %h/%h want 000d/0a00", joystick1, joystick2);
    end
  endtask

  task automatic test_enable_abort;
    int n, falls, loads, cyc;
    bit prev_clk, prev_load, clk_early;
    n = 0;
    while (joy_load && n < 300) begin @(negedge clk); n++; end
    falls = 0; prev_clk = 1'b1; n = 0;
    while (falls < 11 && n < 300) begin
      @(negedge clk);
      n++;
      if (prev_clk && !joy_clk) falls++;
      prev_clk = joy_clk;
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (joy_clk !== 1'b1 || joy_load !== 1'b1) begin
      errors++; $display("FAIL abort_lines: got clk=%b load=%b want 1/1", joy_clk, joy_load);
    end
    checks++;
    if (joystick1 !== 16'h0 || joystick2 !== 16'h0) begin
      errors++; $display("FAIL abort_outputs: got %h/%h want 0000/0000", joystick1, joystick2);
    end
    checks++;
    if (frame_strobe !== 1'b0) begin errors++; $display("FAIL abort_strobe: got %b want 0", frame_strobe); end
    repeat (10) @(negedge clk);
    enable = 1'b1;
    clk_early = 1'b0; n = 0;
    while (joy_load && n < 20) begin
      @(negedge clk);
      n++;
      if (!joy_clk) clk_early = 1'b1;
    end
    checks++;
    if (joy_load !== 1'b0 || clk_early) begin
      errors++; $display("FAIL reenable_load_first: got load=%b clk_early=%b want 0/0", joy_load, clk_early);
    end
    loads = 1; prev_load = 1'b0; cyc = 0;
    while (!frame_strobe && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (prev_load && !joy_load) loads++;
      prev_load = joy_load;
    end
    checks++;
    if (loads != 2 || !frame_strobe) begin
      errors++; $display("FAIL reenable_frames: got %0d frames (strobe %b) want 2", loads, frame_strobe);
    end
    checks++;
    if (joystick1 !== 16'h000D || joystick2 !== 16'h0A00) begin
      errors++; $display("FAIL reenable_data: got %h/%h want 000d/0a00", joystick1, joystick2);
    end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    while (joy_clk && n < 300) begin @(negedge clk); n++; end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (joy_clk !== 1'b1 || joy_load !== 1'b1) begin
      errors++; $display("FAIL async_lines: got clk=%b load=%b want 1/1", joy_clk, joy_load);
    end
    checks++;
    if (joystick1 !== 16'h0 || joystick2 !== 16'h0) begin
      errors++; $display("FAIL async_outputs: got %h/%h want 0000/0000", joystick1, joystick2);
    end
    checks++;
    if (frame_strobe !== 1'b0) begin errors++; $display("FAIL async_strobe: got %b want 0", frame_strobe); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_absent;
    int cyc;
    bit ok;
    absent = 1'b1;
    wait_strobe(300, cyc, ok);
    checks++;
    if (!ok || joystick1 !== 16'h0 || joystick2 !== 16'h0) begin
      errors++; $display("FAIL absent_frame: got %h/%h (strobe %b) want 0000/0000", joystick1, joystick2, ok);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_frame_timing();
    test_decode();
    test_debounce();
    test_enable_abort();
    test_async_reset();
    test_absent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
